neuron_mac: RTL and testbench

- Downstream consumer of the input shift register.
- Takes the packed m-element Q8.24 vector it produces, plus a packed weight vector and a bias, and computes one neuron output: sat(sum(x[i]*w[i]) + b), with optional ReLU.
- Operands are captured on start, so the upstream register may resume shifting immediately.
- Uses one shared multiplier, one product per cycle, under a small FSM with a start/busy/done handshake.

---
 rtl/neuron_mac_pkg.sv | 29 ++
 rtl/neuron_mac_fixed_sat.sv | 44 ++++
 rtl/neuron_mac.sv | 146 ++++++++++++++
 tb/tb_neuron_mac.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron MAC datapath.
//   state_e    : FSM state encoding (idle, multiply-accumulate, finish)
//   DefaultF   : default number of fractional bits
//   sat_max/min: saturation limits of an n-bit signed value, sign-extended to 128 bits
//   acc_width  : accumulator width that cannot overflow for m products plus the bias
package neuron_mac_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StFin  = 2'd2
  } state_e;

  localparam int unsigned DefaultF = 24;

  function automatic logic signed [127:0] sat_max(input int unsigned n);
    return (128'sd1 <<< (n - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_min(input int unsigned n);
    return -(128'sd1 <<< (n - 1));
  endfunction

  // m full-precision products of 2n bits need clog2(m) growth bits; one more covers the bias.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned m);
    return 2 * n + $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/neuron_mac_fixed_sat.sv
// Fixed-point output stage: arithmetic shift right by F (floor), saturate to n bits,
// then optional ReLU. Purely combinational.
//   din     in  W  wide signed value with F fractional bits
//   relu_en in  1  clamp negative results to zero
//   y       out n  saturated / rectified result
//   ovf     out 1  saturation occurred (independent of ReLU)
module neuron_mac_fixed_sat
  import neuron_mac_pkg::*;
#(
  parameter int unsigned W = 67,
  parameter int unsigned n = 32,
  parameter int unsigned F = DefaultF
) (
  input  logic signed [W-1:0] din,
  input  logic                relu_en,
  output logic [n-1:0]        y,
  output logic                ovf
);

  localparam logic signed [127:0] MaxL = sat_max(n);
  localparam logic signed [127:0] MinL = sat_min(n);
  localparam logic signed [W-1:0] MaxW = MaxL[W-1:0];
  localparam logic signed [W-1:0] MinW = MinL[W-1:0];

  logic signed [W-1:0] t;
  assign t = din >>> F;

  always_comb begin
    y   = t[n-1:0];
    ovf = 1'b0;
    if (t > MaxW) begin
      y   = MaxW[n-1:0];
      ovf = 1'b1;
    end else if (t < MinW) begin
      y   = MinW[n-1:0];
      ovf = 1'b1;
    end
    // ovf reports saturation even when ReLU then zeroes the value
    if (relu_en && y[n-1]) begin
      y = '0;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: y = sat((sum x[i]*w[i]) + b), optional ReLU, one shared multiplier.
// Operands are captured on start so the upstream shift register may keep shifting.
//   clk     in  1    clock
//   rst     in  1    asynchronous active-low reset
//   start   in  1    begin a computation (honoured only when idle)
//   x, w    in  m*n  packed vectors, element i at [i*n +: n]
//   b       in  n    bias
//   relu_en in  1    apply ReLU, captured with start
//   busy    out 1    computation in progress
//   done    out 1    one-cycle pulse when y/ovf update
//   y       out n    result, held until next done
//   ovf     out 1    result saturated, held with y
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned n = 32,
  parameter int unsigned F = DefaultF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [m*n-1:0] x,
  input  logic [m*n-1:0] w,
  input  logic [n-1:0]   b,
  input  logic           relu_en,
  output logic           busy,
  output logic           done,
  output logic [n-1:0]   y,
  output logic           ovf
);

  localparam int unsigned AccW = acc_width(n, m);
  localparam int unsigned IdxW = (m > 1) ? $clog2(m) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(m - 1);

  state_e                state_q, state_d;
  logic [m*n-1:0]        xr_q, xr_d, wr_q, wr_d;
  logic [n-1:0]          br_q, br_d;
  logic                  relu_q, relu_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  done_q, done_d;
  logic [n-1:0]          y_q, y_d;
  logic                  ovf_q, ovf_d;

  // Shared multiplier: one element pair per MAC cycle
  logic signed [n-1:0]    xe, we;
  logic signed [2*n-1:0]  prod;
  logic signed [AccW-1:0] prod_ext;
  assign xe       = xr_q[idx_q*n +: n];
  assign we       = wr_q[idx_q*n +: n];
  assign prod     = xe * we;
  assign prod_ext = {{(AccW-2*n){prod[2*n-1]}}, prod};

  // Bias aligned to the product scale (2F fractional bits) before the final shift
  logic signed [AccW-1:0] bias_ext, sum;
  assign bias_ext = {{(AccW-n){br_q[n-1]}}, br_q};
  assign sum      = acc_q + (bias_ext <<< F);

  logic [n-1:0] y_sat;
  logic         ovf_sat;

  neuron_mac_fixed_sat #(
    .W (AccW),
    .n (n),
    .F (F)
  ) u_fixed_sat (
    .din     (sum),
    .relu_en (relu_q),
    .y       (y_sat),
    .ovf     (ovf_sat)
  );

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    wr_d    = wr_q;
    br_d    = br_q;
    relu_d  = relu_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    y_d     = y_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          xr_d    = x;
          wr_d    = w;
          br_d    = b;
          relu_d  = relu_en;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxLast) begin
          state_d = StFin;
        end
      end
      StFin: begin
        y_d     = y_sat;
        ovf_d   = ovf_sat;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      xr_q    <= '0;
      wr_q    <= '0;
      br_q    <= '0;
      relu_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      wr_q    <= wr_d;
      br_q    <= br_d;
      relu_q  <= relu_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign y    = y_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac (m=4, n=32, F=24) with hand-computed expected results.
module tb_neuron_mac;

  localparam int unsigned M = 4;
  localparam int unsigned N = 32;

  localparam logic [31:0] One     = 32'h0100_0000;
  localparam logic [31:0] Half    = 32'h0080_0000;
  localparam logic [31:0] NHalf   = 32'hFF80_0000;
  localparam logic [31:0] Quarter = 32'h0040_0000;
  localparam logic [31:0] NOne    = 32'hFF00_0000;
  localparam logic [31:0] Hund    = 32'h6400_0000;
  localparam logic [31:0] NHund   = 32'h9C00_0000;

  logic           clk;
  logic           rst;
  logic           start;
  logic [M*N-1:0] x;
  logic [M*N-1:0] w;
  logic [N-1:0]   b;
  logic           relu_en;
  logic           busy;
  logic           done;
  logic [N-1:0]   y;
  logic           ovf;

  int n_cmp;
  int n_err;
  int lat;

  neuron_mac #(
    .m (M),
    .n (N),
    .F (24)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x       (x),
    .w       (w),
    .b       (b),
    .relu_en (relu_en),
    .busy    (busy),
    .done    (done),
    .y       (y),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M*N-1:0] rep4(input logic [31:0] v);
    return {4{v}};
  endfunction

  // Ticks until done is seen; lat counts edges waited, capped at a budget
  task automatic wait_done(output int l);
    l = 0;
    while (!done && l < 20) begin
      tick();
      l++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: done not seen within 20 cycles");
    end
  endtask

  // Captures operands at the next edge (E0); l = edges after E0 until done
  task automatic do_op(input logic [M*N-1:0] xv, input logic [M*N-1:0] wv,
                       input logic [31:0] bv, input logic re, output int l);
    x       = xv;
    w       = wv;
    b       = bv;
    relu_en = re;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_done(l);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b0;
    start   = 1'b0;
    x       = '0;
    w       = '0;
    b       = '0;
    relu_en = 1'b0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic dot product, latency and busy shape
    x = rep4(One); w = rep4(Half); b = Quarter; relu_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("basic_busy_after_e0", 64'(busy), 64'd1);
    wait_done(lat);
    check("basic_lat", 64'(lat), 64'd5);
    check("basic_busy_at_done", 64'(busy), 64'd0);
    check("basic_y", 64'(y), 64'h0240_0000);
    check("basic_ovf", 64'(ovf), 64'd0);
    tick();
    check("done_pulse_len", 64'(done), 64'd0);
    check("y_held", 64'(y), 64'h0240_0000);

    // Negative result and ReLU
    do_op(rep4(One), rep4(NOne), 32'h0, 1'b0, lat);
    check("neg_y", 64'(y), 64'hFC00_0000);
    check("neg_ovf", 64'(ovf), 64'd0);
    tick();
    do_op(rep4(One), rep4(NOne), 32'h0, 1'b1, lat);
    check("neg_relu_y", 64'(y), 64'h0);
    check("neg_relu_ovf", 64'(ovf), 64'd0);
    tick();

    // Saturation
    do_op(rep4(Hund), rep4(Hund), 32'h0, 1'b0, lat);
    check("satp_y", 64'(y), 64'h7FFF_FFFF);
    check("satp_ovf", 64'(ovf), 64'd1);
    tick();
    do_op(rep4(Hund), rep4(NHund), 32'h0, 1'b0, lat);
    check("satn_y", 64'(y), 64'h8000_0000);
    check("satn_ovf", 64'(ovf), 64'd1);
    tick();
    do_op(rep4(Hund), rep4(NHund), 32'h0, 1'b1, lat);
    check("satn_relu_y", 64'(y), 64'h0);
    check("satn_relu_ovf", 64'(ovf), 64'd1);
    tick();

    // Floor truncation on the smallest representable product
    do_op({96'h0, 32'h0000_0001}, {96'h0, Half}, 32'h0, 1'b0, lat);
    check("floor_pos_y", 64'(y), 64'h0);
    tick();
    do_op({96'h0, 32'h0000_0001}, {96'h0, NHalf}, 32'h0, 1'b0, lat);
    check("floor_neg_y", 64'(y), 64'hFFFF_FFFF);
    tick();

    // Start while busy is ignored; operand changes after capture have no effect
    x = rep4(One); w = rep4(Half); b = Quarter; relu_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    x = rep4(Hund); b = 32'h0; relu_en = 1'b1;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 64'(lat), 64'd2);
    check("ign_y", 64'(y), 64'h0240_0000);
    tick();
    check("ign_no_second_busy", 64'(busy), 64'd0);

    // Back-to-back: start during the done cycle
    do_op(rep4(One), rep4(Half), Quarter, 1'b0, lat);
    check("b2b_first_y", 64'(y), 64'h0240_0000);
    do_op(rep4(One), rep4(NOne), 32'h0, 1'b0, lat);
    check("b2b_lat", 64'(lat), 64'd5);
    check("b2b_second_y", 64'(y), 64'hFC00_0000);
    tick();

    // Reset mid-operation (idx=2), y currently non-zero
    x = rep4(Hund); w = rep4(Hund); b = 32'h0; relu_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_y", 64'(y), 64'h0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_no_done", 64'(done), 64'd0);
    end
    do_op(rep4(One), rep4(Half), Quarter, 1'b0, lat);
    check("post_rst_lat", 64'(lat), 64'd5);
    check("post_rst_y", 64'(y), 64'h0240_0000);
    check("post_rst_ovf", 64'(ovf), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
